ram_loader: RTL and testbench
=============================

Name: ram_loader

Overview:
- Bus-mastering program loader: the writing end of the RAM interface the CPU reads.
- Accepts a byte stream over a valid/ready handshake while the CPU is held.
- Writes each byte into consecutive RAM locations 0..MEM_DEPTH-1 by driving the shared 8-bit bus and pulsing the MI and RI strobes, exactly as a microcode fetch sequence would.
- Sits beside the RAM at top level; its bus driver and strobes are ORed with the CPU control word.

Parameters:
- MEM_DEPTH, 16, number of RAM locations written per load; power of two, ≤ 2^ADDR_W.
- ADDR_W, 4, RAM address width; the address is driven on bus[ADDR_W-1:0] with upper bits zero.

Ports:
- clk  input  1  system clock; single clock domain.
- clr  input  1  synchronous active-high reset.
- start  input  1  one-cycle request to begin a load; sampled only in IDLE.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts in_data this cycle.
- bus_out  output  8  value driven onto the shared bus.
- bus_oe  output  1  bus_out is driven; 0 means tri-state.
- mi  output  1  memory address register load strobe.
- ri  output  1  RAM write strobe.
- cpu_hold  output  1  holds the CPU clock stopped or in clear while loading.
- busy  output  1  load in progress.
- done  output  1  one-cycle pulse when a load completes.
- addr  output  ADDR_W  next RAM address to be written.
- csum_err  output  1  checksum mismatch flag (see Optional Feature).

Behaviour:
- Reset (clr=1 at a clk edge): state IDLE, addr=0, in_ready=0, bus_oe=0, bus_out=0, mi=0, ri=0, cpu_hold=0, busy=0, done=0, csum_err=0, data and sum registers cleared.
- clr mid-load aborts immediately with the same values. The partially written RAM is left as is.
- All outputs are registered except in_ready, which is decoded from state (high only in WAIT_BYTE).
- States:
  - IDLE: start=1 → WAIT_BYTE; addr←0, busy←1, cpu_hold←1. Clears csum_err and sum.
  - WAIT_BYTE: in_ready=1. On in_valid&in_ready, latch in_data → ADDR. Otherwise stay; no timeout.
  - ADDR (1 cycle): bus_oe=1, bus_out={0,addr}, mi=1 → DATA.
  - DATA (1 cycle): bus_oe=1, bus_out=latched byte, ri=1; sum←sum+byte (mod 256).
    - If addr==MEM_DEPTH-1 → FINISH. Otherwise addr←addr+1 → WAIT_BYTE.
  - FINISH (1 cycle): done=1, busy←0, cpu_hold←0, addr←0 (wraps) → IDLE.
- Timing:
  - Byte accepted at edge N: mi is high during cycle N+1, ri during N+2, in_ready is high again from N+3.
  - Minimum of 3 cycles per byte.
- Control rules:
  - mi and ri are never high in the same cycle.
  - bus_oe is high only in ADDR and DATA.
  - start is ignored outside IDLE.
  - in_valid is ignored when in_ready=0; the byte stays pending on the source side.
- Simultaneous start and clr: clr wins.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Enabled:
  - After the MEM_DEPTH-th byte's DATA cycle, go to WAIT_SUM (in_ready=1) instead of FINISH.
  - Accept one extra byte, with no bus activity. csum_err←(byte != sum), then FINISH.
  - csum_err holds until the next start or clr.
- Disabled: no WAIT_SUM state; csum_err is tied 0.

Test Plan:
- Reset, then start and stream 0x00..0x0F with in_valid held high → 16 MI/RI pairs. MI bus values 0x00..0x0F, RI bus values matching. done pulses once. addr returns to 0, cpu_hold falls in the FINISH cycle.
- Throughput: byte 0x5A accepted at edge N → mi=1 and bus=0x00 in cycle N+1; ri=1 and bus=0x5A in N+2; in_ready=1 at N+3. Never mi&ri; bus_oe=0 in WAIT_BYTE.
- Source stalls 10 cycles between bytes → state holds, bus_oe=0, no strobes; load completes correctly.
- Assert clr after the 5th byte's MI cycle → next cycle all outputs are at reset values, no ri. A new start reloads from addr 0.
- Pulse start while busy → ignored; the byte count is still 16.
- LOADER_CHECKSUM_EN: bytes 0x01 x16 then 0x10 → csum_err=0. Repeat with a trailing 0x11 → csum_err=1 after done, cleared by the next start.

Source files
------------

// File: rtl/ram_loader_if.sv
// Loader handshake and shared-bus signals.
// The loader is the master; the system/stream side is the slave.
interface ram_loader_if #(
    parameter int ADDR_W = 4
) ();
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        bus_out;
    logic              bus_oe;
    logic              mi;
    logic              ri;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] addr;
    logic              csum_err;

    modport master (
        input  start, in_data, in_valid,
        output in_ready, bus_out, bus_oe, mi, ri,
        output cpu_hold, busy, done, addr, csum_err
    );

    modport slave (
        output start, in_data, in_valid,
        input  in_ready, bus_out, bus_oe, mi, ri,
        input  cpu_hold, busy, done, addr, csum_err
    );
endinterface

// File: rtl/ram_loader.sv
// Program loader: streams bytes into RAM via MI/RI bus cycles while the CPU is held.
// LOADER_CHECKSUM_EN adds a trailing checksum byte check (csum_err).
module ram_loader #(
    parameter int MEM_DEPTH = 16,
    parameter int ADDR_W    = 4
) (
    input  logic         clk,
    input  logic         clr,
    ram_loader_if.master lif
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BYTE,
        S_ADDR,
        S_DATA,
        S_FINISH
`ifdef LOADER_CHECKSUM_EN
        , S_WAIT_SUM
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic [7:0]        bus_out_q, bus_out_d;
    logic              bus_oe_q, bus_oe_d;
    logic              mi_q, mi_d;
    logic              ri_q, ri_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              to_finish;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
    logic              csum_err_q, csum_err_d;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        bus_out_d  = 8'h00;
        bus_oe_d   = 1'b0;
        mi_d       = 1'b0;
        ri_d       = 1'b0;
        cpu_hold_d = cpu_hold_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        to_finish  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        sum_d      = sum_q;
        csum_err_d = csum_err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (lif.start) begin
                    state_d    = S_WAIT_BYTE;
                    addr_d     = '0;
                    busy_d     = 1'b1;
                    cpu_hold_d = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    sum_d      = 8'h00;
                    csum_err_d = 1'b0;
`endif
                end
            end
            S_WAIT_BYTE: begin
                // Outputs are registered, so the MI cycle is set up on accept.
                if (lif.in_valid) begin
                    data_d    = lif.in_data;
                    state_d   = S_ADDR;
                    bus_oe_d  = 1'b1;
                    bus_out_d = 8'(addr_q);
                    mi_d      = 1'b1;
                end
            end
            S_ADDR: begin
                state_d   = S_DATA;
                bus_oe_d  = 1'b1;
                bus_out_d = data_q;
                ri_d      = 1'b1;
            end
            S_DATA: begin
`ifdef LOADER_CHECKSUM_EN
                sum_d = sum_q + data_q;
`endif
                if (addr_q == LAST) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_WAIT_SUM;
`else
                    to_finish = 1'b1;
`endif
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = S_WAIT_BYTE;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
`ifdef LOADER_CHECKSUM_EN
            S_WAIT_SUM: begin
                if (lif.in_valid) begin
                    csum_err_d = (lif.in_data != sum_q);
                    to_finish  = 1'b1;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (to_finish) begin
            state_d    = S_FINISH;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            cpu_hold_d = 1'b0;
            addr_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            data_q     <= 8'h00;
            bus_out_q  <= 8'h00;
            bus_oe_q   <= 1'b0;
            mi_q       <= 1'b0;
            ri_q       <= 1'b0;
            cpu_hold_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= 8'h00;
            csum_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            bus_out_q  <= bus_out_d;
            bus_oe_q   <= bus_oe_d;
            mi_q       <= mi_d;
            ri_q       <= ri_d;
            cpu_hold_q <= cpu_hold_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
            csum_err_q <= csum_err_d;
`endif
        end
    end

`ifdef LOADER_CHECKSUM_EN
    assign lif.in_ready = (state_q == S_WAIT_BYTE) ||
                          (state_q == S_WAIT_SUM);
    assign lif.csum_err = csum_err_q;
`else
    assign lif.in_ready = (state_q == S_WAIT_BYTE);
    assign lif.csum_err = 1'b0;
`endif
    assign lif.bus_out  = bus_out_q;
    assign lif.bus_oe   = bus_oe_q;
    assign lif.mi       = mi_q;
    assign lif.ri       = ri_q;
    assign lif.cpu_hold = cpu_hold_q;
    assign lif.busy     = busy_q;
    assign lif.done     = done_q;
    assign lif.addr     = addr_q;
endmodule

// File: tb/tb_ram_loader.sv
// Scoreboard bench for ram_loader: byte-index/sum model feeds expectation queues,
// a negedge monitor pops them whenever the DUT strobes MI, RI or done.
module tb_ram_loader;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clk = 1'b0;
    logic clr = 1'b1;

    ram_loader_if #(.ADDR_W(AW)) lif ();

    ram_loader #(
        .MEM_DEPTH(DEPTH),
        .ADDR_W   (AW)
    ) dut (
        .clk(clk),
        .clr(clr),
        .lif(lif)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } exp_t;

    exp_t mi_q[$];
    exp_t ri_q[$];
    exp_t rdy_q[$];
    exp_t done_q[$];

    int         tests = 0;
    int         fails = 0;
    int         idx   = 0;
    logic [7:0] msum  = 8'h00;

    function automatic void check(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at edge %0d",
                     name, act, exp, edge_cnt);
        end
    endfunction

    // Monitor: pops expectations when the DUT presents a strobe.
    always @(negedge clk) begin
        exp_t e;
        if (lif.mi === 1'b1) begin
            if (mi_q.size() == 0) check("mi_unexpected", 1, 0);
            else begin
                e = mi_q.pop_front();
                check("mi_cycle", edge_cnt, e.cyc);
                check("mi_bus", int'(lif.bus_out), int'(e.val));
                check("mi_hold", int'(lif.cpu_hold), 1);
            end
        end
        if (lif.ri === 1'b1) begin
            if (ri_q.size() == 0) check("ri_unexpected", 1, 0);
            else begin
                e = ri_q.pop_front();
                check("ri_cycle", edge_cnt, e.cyc);
                check("ri_bus", int'(lif.bus_out), int'(e.val));
            end
        end
        if (lif.done === 1'b1) begin
            if (done_q.size() == 0) check("done_unexpected", 1, 0);
            else begin
                e = done_q.pop_front();
                check("done_cycle", edge_cnt, e.cyc);
                check("done_addr", int'(lif.addr), 0);
                check("done_hold", int'(lif.cpu_hold), 0);
                check("done_busy", int'(lif.busy), 0);
                check("done_csum", int'(lif.csum_err), int'(e.val));
            end
        end
        if (rdy_q.size() > 0 && rdy_q[0].cyc == edge_cnt) begin
            e = rdy_q.pop_front();
            check("ready_again", int'(lif.in_ready), 1);
        end
        if (mi_q.size() > 0 && mi_q[0].cyc < edge_cnt) begin
            e = mi_q.pop_front();
            check("mi_missing", 0, 1);
        end
        if (ri_q.size() > 0 && ri_q[0].cyc < edge_cnt) begin
            e = ri_q.pop_front();
            check("ri_missing", 0, 1);
        end
        if (done_q.size() > 0 && done_q[0].cyc < edge_cnt) begin
            e = done_q.pop_front();
            check("done_missing", 0, 1);
        end
        check("mi_ri_excl", int'(lif.mi & lif.ri), 0);
        check("bus_oe_strobe", int'(lif.bus_oe), int'(lif.mi | lif.ri));
        check("ready_no_bus", int'(lif.in_ready & lif.bus_oe), 0);
    end

    task automatic check_idle(input string name, input logic exp_csum);
        check({name, "_in_ready"}, int'(lif.in_ready), 0);
        check({name, "_bus_oe"}, int'(lif.bus_oe), 0);
        check({name, "_bus_out"}, int'(lif.bus_out), 0);
        check({name, "_mi"}, int'(lif.mi), 0);
        check({name, "_ri"}, int'(lif.ri), 0);
        check({name, "_hold"}, int'(lif.cpu_hold), 0);
        check({name, "_busy"}, int'(lif.busy), 0);
        check({name, "_done"}, int'(lif.done), 0);
        check({name, "_addr"}, int'(lif.addr), 0);
        check({name, "_csum"}, int'(lif.csum_err), int'(exp_csum));
    endtask

    // Called at a negedge while the loader is idle.
    task automatic do_start();
        lif.start = 1'b1;
        @(negedge clk);
        lif.start = 1'b0;
        idx  = 0;
        msum = 8'h00;
        check("start_busy", int'(lif.busy), 1);
        check("start_hold", int'(lif.cpu_hold), 1);
        check("start_csum", int'(lif.csum_err), 0);
    endtask

    // Offer one byte; returns at the negedge after the accepting edge.
    task automatic offer(input logic [7:0] b, input int gap, output int n);
        int t;
        if (gap > 0) begin
            lif.in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        lif.in_data  = b;
        lif.in_valid = 1'b1;
        t = 0;
        while (lif.in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        n = edge_cnt + 1;
        if (lif.in_ready !== 1'b1) begin
            check("ready_timeout", 0, 1);
            n = -100;
        end
        @(negedge clk);
    endtask

    task automatic send_data(input logic [7:0] b, input int gap);
        int n;
        offer(b, gap, n);
        if (n < 0) return;
        mi_q.push_back('{n, 8'(idx)});
        ri_q.push_back('{n + 1, b});
        msum = msum + b;
        if (idx == DEPTH - 1) begin
`ifdef LOADER_CHECKSUM_EN
            rdy_q.push_back('{n + 2, 8'h00});
`else
            done_q.push_back('{n + 2, 8'h00});
`endif
        end else begin
            rdy_q.push_back('{n + 2, 8'h00});
        end
        idx++;
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic send_sum(input logic [7:0] b, input int gap);
        int n;
        offer(b, gap, n);
        if (n < 0) return;
        done_q.push_back('{n, (b != msum) ? 8'h01 : 8'h00});
    endtask
`endif

    task automatic wait_done();
        int t;
        lif.in_valid = 1'b0;
        t = 0;
        while (done_q.size() > 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (done_q.size() > 0) begin
            check("done_timeout", 0, 1);
            done_q.delete();
        end
        @(negedge clk);
    endtask

    function automatic int rand_gap();
        if ($urandom_range(0, 7) == 0) return 10;
        return int'($urandom_range(0, 2));
    endfunction

    // Closes a load; a bad checksum byte is used when good is 0.
    task automatic close_load(input logic good);
        logic exp_csum;
        exp_csum = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        send_sum(good ? msum : msum + 8'h01, rand_gap());
        exp_csum = ~good;
`endif
        wait_done();
        check_idle("after_load", exp_csum);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        lif.start    = 1'b0;
        lif.in_data  = 8'h00;
        lif.in_valid = 1'b0;
        clr          = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("reset", 1'b0);
        clr = 1'b0;

        // Counting pattern with in_valid held high.
        do_start();
        for (int i = 0; i < DEPTH; i++) send_data(8'(i), 0);
        close_load(1'b1);

        // Throughput: leading 0x5A, back-to-back.
        do_start();
        send_data(8'h5A, 0);
        for (int i = 1; i < DEPTH; i++) send_data(8'($urandom), 0);
        close_load(1'b1);

        // Source stalls of 10 cycles between bytes.
        do_start();
        for (int i = 0; i < DEPTH; i++) send_data(8'($urandom), 10);
        close_load(1'b1);

        // Abort after the 5th byte's MI cycle.
        do_start();
        for (int i = 0; i < 5; i++) send_data(8'($urandom), 0);
        #1;
        clr = 1'b1;
        lif.in_valid = 1'b0;
        mi_q.delete();
        ri_q.delete();
        rdy_q.delete();
        done_q.delete();
        @(negedge clk);
        check_idle("abort", 1'b0);
        clr = 1'b0;
        do_start();
        for (int i = 0; i < DEPTH; i++) send_data(8'($urandom), rand_gap());
        close_load(1'b1);

        // Start pulses while busy must be ignored.
        do_start();
        for (int i = 0; i < DEPTH; i++) begin
            send_data(8'($urandom), 0);
            if (i == 3 || i == 9) begin
                lif.in_valid = 1'b0;
                lif.start    = 1'b1;
                @(negedge clk);
                lif.start    = 1'b0;
                @(negedge clk);
                lif.start    = 1'b1;
                @(negedge clk);
                lif.start    = 1'b0;
            end
        end
        close_load(1'b1);

        // Random loads.
        for (int k = 0; k < 4; k++) begin
            do_start();
            for (int i = 0; i < DEPTH; i++) send_data(8'($urandom), rand_gap());
            close_load(($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0);
        end

`ifdef LOADER_CHECKSUM_EN
        do_start();
        for (int i = 0; i < DEPTH; i++) send_data(8'h01, 0);
        send_sum(8'h10, 0);
        wait_done();
        check_idle("csum_ok", 1'b0);

        do_start();
        for (int i = 0; i < DEPTH; i++) send_data(8'h01, 0);
        send_sum(8'h11, 0);
        wait_done();
        check_idle("csum_bad", 1'b1);
        repeat (3) @(negedge clk);
        check("csum_held", int'(lif.csum_err), 1);
        do_start();
        for (int i = 0; i < DEPTH; i++) send_data(8'($urandom), 0);
        close_load(1'b1);
`endif

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
